// File: rtl/muldiv_issue_arbiter_pkg.sv
// Shared types and widths for the mul/div issue arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the core-wide widths, the ALU command encoding for the mul/div unit,
// the arbiter FSM state type and the packed operation payload that is latched
// on accept.
package muldiv_issue_arbiter_pkg;

  localparam int XLEN                 = 32;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int DISPATCH_ADDR_WIDTH  = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;
  localparam int PHYS_REGS_ADDR_WIDTH = 7;
  localparam int ROB_ADDR_WIDTH       = 6;

  typedef enum logic [2:0] {
    ALU_MUL    = 3'd0,
    ALU_MULH   = 3'd1,
    ALU_MULHSU = 3'd2,
    ALU_MULHU  = 3'd3,
    ALU_DIV    = 3'd4,
    ALU_DIVU   = 3'd5,
    ALU_REM    = 3'd6,
    ALU_REMU   = 3'd7
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } arb_state_t;

  // Everything about an op that has to survive from accept to writeback.
  typedef struct packed {
    alu_cmd_t                        alu_cmd;
    logic [XLEN-1:0]                 op1;
    logic [XLEN-1:0]                 op2;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
  } mdu_op_t;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muldiv_issue_arbiter_rr_picker.sv
// Round-robin picker (rr_picker): first valid requester at or above the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   i_valid  - request vector, bit i = requester i
//   i_ptr    - highest-priority requester index this cycle
//   o_grant  - one-hot grant (all zero when nothing is valid)
//   o_idx    - index of the granted requester (0 when nothing is valid)
//   o_any    - at least one requester is valid
module muldiv_issue_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W + 1)'(NUM_REQ);

  always_comb begin
    logic           w_found;
    logic [IDX_W:0] w_pos;
    w_found = 1'b0;
    w_pos   = '0;
    o_grant = '0;
    o_idx   = '0;
    // Walk ptr, ptr+1, ... with wrap; one extra bit keeps the sum from overflowing
    // before the modulo subtraction.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_pos >= NUM_REQ_L) begin
        w_pos = w_pos - NUM_REQ_L;
      end
      if (!w_found && i_valid[w_pos[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/muldiv_issue_arbiter.sv
// Shares one mul/div unit between NUM_REQ issue banks: round-robin accept, run, write back.
// Latency: accept -> unit_start next cycle; unit_done -> wb_valid next cycle.
// Backpressure: one op in flight; req_ready low outside IDLE, wb_valid held until wb_ready.
//
// Optional feature: define MULDIV_ARB_STATS_EN to add the o_stat_grants and
// o_stat_busy_cycles counters (32-bit, wrapping, cleared only by reset).
//
// Ports:
//   i_clk, i_rst        - clock, asynchronous active-low reset
//   i_flush             - abandons any in-flight op, returns to IDLE
//   i_req_* / o_req_ready - per-bank op offer and accept
//   o_unit_*            - start/kill pulses and latched operation to the unit
//   i_unit_done/_result - unit completion pulse and result
//   o_wb_* / i_wb_ready - writeback payload and handshake
module muldiv_issue_arbiter
  import muldiv_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DISPATCH_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  alu_cmd_t                        i_req_alu_cmd  [NUM_REQ],
  input  logic [XLEN-1:0]                 i_req_op1      [NUM_REQ],
  input  logic [XLEN-1:0]                 i_req_op2      [NUM_REQ],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] i_req_phys_rd  [NUM_REQ],
  input  logic [ROB_ADDR_WIDTH-1:0]       i_req_rob_addr [NUM_REQ],
  output logic                            o_unit_start,
  output logic                            o_unit_kill,
  output alu_cmd_t                        o_unit_alu_cmd,
  output logic [XLEN-1:0]                 o_unit_op1,
  output logic [XLEN-1:0]                 o_unit_op2,
  input  logic                            i_unit_done,
  input  logic [XLEN-1:0]                 i_unit_result,
  output logic                            o_wb_valid,
  input  logic                            i_wb_ready,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] o_wb_phys_rd,
  output logic [ROB_ADDR_WIDTH-1:0]       o_wb_rob_addr,
  output logic [XLEN-1:0]                 o_wb_data,
  output logic [DISPATCH_ADDR_WIDTH-1:0]  o_wb_bank
`ifdef MULDIV_ARB_STATS_EN
  ,
  output logic [31:0]                     o_stat_grants,
  output logic [31:0]                     o_stat_busy_cycles
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_bank;
  mdu_op_t          r_op;
  logic [XLEN-1:0]  r_wb_data;
  logic             r_unit_start;
  logic             r_wb_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_open;
  logic               w_accept;
  logic [IDX_W-1:0]   w_next_ptr;
  mdu_op_t            w_req_op;

  muldiv_issue_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_valid (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are only offered in IDLE, outside flush, and never while reset is
  // held (the state register already reads IDLE during reset, so the reset
  // level itself has to gate the combinational ready).
  assign w_open      = (r_state == ST_IDLE) && !i_flush && i_rst;
  assign o_req_ready = w_open ? w_grant : '0;
  assign w_accept    = w_open && w_any;

  assign w_next_ptr = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

  always_comb begin
    w_req_op          = '0;
    w_req_op.alu_cmd  = i_req_alu_cmd[w_idx];
    w_req_op.op1      = i_req_op1[w_idx];
    w_req_op.op2      = i_req_op2[w_idx];
    w_req_op.phys_rd  = i_req_phys_rd[w_idx];
    w_req_op.rob_addr = i_req_rob_addr[w_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_bank       <= '0;
      r_op         <= '0;
      r_wb_data    <= '0;
      r_unit_start <= 1'b0;
      r_wb_valid   <= 1'b0;
    end else begin
      r_unit_start <= 1'b0;
      if (i_flush) begin
        // A writeback handshaking in this same cycle has already completed;
        // dropping wb_valid here is all that is needed. rr_ptr is untouched.
        r_state    <= ST_IDLE;
        r_wb_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_op         <= w_req_op;
              r_bank       <= w_idx;
              r_rr_ptr     <= w_next_ptr;
              r_unit_start <= 1'b1;
              r_state      <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            // A done coinciding with our own start pulse belongs to an older,
            // killed op still draining out of the unit, so it is dropped.
            if (i_unit_done && !r_unit_start) begin
              r_wb_data  <= i_unit_result;
              r_wb_valid <= 1'b1;
              r_state    <= ST_WB;
            end
          end
          ST_WB: begin
            if (i_wb_ready) begin
              r_wb_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
          default: begin
            r_wb_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_unit_start   = r_unit_start;
  assign o_unit_kill    = i_flush && (r_state == ST_BUSY);
  assign o_unit_alu_cmd = r_op.alu_cmd;
  assign o_unit_op1     = r_op.op1;
  assign o_unit_op2     = r_op.op2;

  assign o_wb_valid    = r_wb_valid;
  assign o_wb_phys_rd  = r_op.phys_rd;
  assign o_wb_rob_addr = r_op.rob_addr;
  assign o_wb_data     = r_wb_data;
  assign o_wb_bank     = DISPATCH_ADDR_WIDTH'(r_bank);

`ifdef MULDIV_ARB_STATS_EN
  logic [31:0] r_stat_grants;
  logic [31:0] r_stat_busy_cycles;

  // Counters survive flush on purpose: they measure unit utilisation over time.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stat_grants      <= '0;
      r_stat_busy_cycles <= '0;
    end else begin
      if (w_accept) begin
        r_stat_grants <= r_stat_grants + 32'd1;
      end
      if (r_state != ST_IDLE) begin
        r_stat_busy_cycles <= r_stat_busy_cycles + 32'd1;
      end
    end
  end

  assign o_stat_grants      = r_stat_grants;
  assign o_stat_busy_cycles = r_stat_busy_cycles;
`endif

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Bench for muldiv_issue_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_muldiv_issue_arbiter;
  import muldiv_issue_arbiter_pkg::*;

  localparam int N = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  alu_cmd_t                        req_cmd [N];
  logic [31:0]                     req_op1 [N];
  logic [31:0]                     req_op2 [N];
  logic [PHYS_REGS_ADDR_WIDTH-1:0] req_rd  [N];
  logic [ROB_ADDR_WIDTH-1:0]       req_rob [N];
  logic        unit_start, unit_kill;
  alu_cmd_t    unit_cmd;
  logic [31:0] unit_op1, unit_op2;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        wb_valid, wb_ready;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_rd;
  logic [ROB_ADDR_WIDTH-1:0]       wb_rob;
  logic [31:0]                     wb_data;
  logic [DISPATCH_ADDR_WIDTH-1:0]  wb_bank;
`ifdef MULDIV_ARB_STATS_EN
  logic [31:0] stat_grants, stat_busy;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_issue_arbiter #(.NUM_REQ(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_flush        (flush),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_alu_cmd  (req_cmd),
    .i_req_op1      (req_op1),
    .i_req_op2      (req_op2),
    .i_req_phys_rd  (req_rd),
    .i_req_rob_addr (req_rob),
    .o_unit_start   (unit_start),
    .o_unit_kill    (unit_kill),
    .o_unit_alu_cmd (unit_cmd),
    .o_unit_op1     (unit_op1),
    .o_unit_op2     (unit_op2),
    .i_unit_done    (unit_done),
    .i_unit_result  (unit_result),
    .o_wb_valid     (wb_valid),
    .i_wb_ready     (wb_ready),
    .o_wb_phys_rd   (wb_rd),
    .o_wb_rob_addr  (wb_rob),
    .o_wb_data      (wb_data),
    .o_wb_bank      (wb_bank)
`ifdef MULDIV_ARB_STATS_EN
    ,
    .o_stat_grants      (stat_grants),
    .o_stat_busy_cycles (stat_busy)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One op at a time: either nothing held, an op executing (age = cycles since
  // its start pulse), or a result waiting for writeback.
  int       m_rr = 0;
  bit       m_exec = 0;
  bit       m_wb = 0;
  int       m_age = 0;
  mdu_op_t  m_op;
  int       m_bank = 0;
  logic [31:0] m_data;
  int unsigned m_grants = 0;
  int unsigned m_busy_cnt = 0;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!rst_n || flush || m_exec || m_wb) return r;
    for (int k = 0; k < N; k++) begin
      int b;
      b = (m_rr + k) % N;
      if (req_valid[b]) begin
        r[b] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] g;
    if (!rst_n) begin
      m_rr = 0; m_exec = 0; m_wb = 0; m_age = 0; m_grants = 0; m_busy_cnt = 0;
    end else begin
      g = exp_ready();
      if (m_exec || m_wb) m_busy_cnt++;
      if (flush) begin
        m_exec = 0;
        m_wb   = 0;
      end else if (m_wb) begin
        if (wb_ready) m_wb = 0;
      end else if (m_exec) begin
        if (unit_done && m_age > 0) begin
          m_exec = 0;
          m_wb   = 1;
          m_data = unit_result;
        end
        m_age++;
      end else begin
        for (int b = 0; b < N; b++) begin
          if (g[b]) begin
            m_op.alu_cmd  = req_cmd[b];
            m_op.op1      = req_op1[b];
            m_op.op2      = req_op2[b];
            m_op.phys_rd  = req_rd[b];
            m_op.rob_addr = req_rob[b];
            m_bank = b;
            m_rr   = (b + 1) % N;
            m_exec = 1;
            m_age  = 0;
            m_grants++;
          end
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_unit_start", unit_start, 0);
      chk("rst_unit_kill", unit_kill, 0);
      chk("rst_unit_op1", unit_op1, 0);
      chk("rst_wb_data", wb_data, 0);
    end else begin
      chk("req_ready", req_ready, exp_ready());
      chk("unit_start", unit_start, m_exec && (m_age == 0));
      chk("unit_kill", unit_kill, flush && m_exec);
      chk("wb_valid", wb_valid, m_wb);
      if (m_exec) begin
        chk("unit_cmd", unit_cmd, m_op.alu_cmd);
        chk("unit_op1", unit_op1, m_op.op1);
        chk("unit_op2", unit_op2, m_op.op2);
      end
      if (m_wb) begin
        chk("wb_data", wb_data, m_data);
        chk("wb_phys_rd", wb_rd, m_op.phys_rd);
        chk("wb_rob_addr", wb_rob, m_op.rob_addr);
        chk("wb_bank", wb_bank, m_bank);
      end
`ifdef MULDIV_ARB_STATS_EN
      chk("stat_grants", stat_grants, m_grants);
      chk("stat_busy_cycles", stat_busy, m_busy_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid   = '0;
    flush       = 1'b0;
    unit_done   = 1'b0;
    unit_result = '0;
    wb_ready    = 1'b0;
  endtask

  task automatic set_bank(input int b, input alu_cmd_t c, input logic [31:0] a,
                          input logic [31:0] d, input int rd, input int rob);
    req_cmd[b] = c;
    req_op1[b] = a;
    req_op2[b] = d;
    req_rd[b]  = PHYS_REGS_ADDR_WIDTH'(rd);
    req_rob[b] = ROB_ADDR_WIDTH'(rob);
  endtask

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got no finish, expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    rst_n = 1'b0;
    clr();
    set_bank(0, ALU_MUL, 32'd6, 32'd7, 5, 9);
    set_bank(1, ALU_DIV, 32'd100, 32'd4, 11, 12);
    req_valid = 2'b11;
    step(); step();
    @(negedge clk);
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_wb_valid", wb_valid, 0);
    step(); rst_n = 1'b1;

    // Both banks valid from reset: bank0 first, 6*7 returns 42 after 3 cycles.
    @(negedge clk); chk("t1_grant_bank0", req_ready, 2'b01);
    step(); req_valid = 2'b10;
    @(negedge clk);
    chk("t1_start", unit_start, 1);
    chk("t1_op1", unit_op1, 6);
    chk("t1_op2", unit_op2, 7);
    chk("t1_cmd", unit_cmd, ALU_MUL);
    chk("t1_busy_ready", req_ready, 2'b00);
    step();
    @(negedge clk); chk("t1_start_once", unit_start, 0);
    step();
    step(); unit_done = 1'b1; unit_result = 32'd42;
    @(negedge clk); chk("t1_no_wb_yet", wb_valid, 0);
    step(); unit_done = 1'b0; unit_result = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_hold_wb_valid", wb_valid, 1);
      chk("t1_hold_wb_data", wb_data, 42);
      chk("t1_hold_phys_rd", wb_rd, 5);
      chk("t1_hold_rob", wb_rob, 9);
      chk("t1_hold_bank", wb_bank, 0);
      chk("t1_hold_ready", req_ready, 2'b00);
      step();
    end
    wb_ready = 1'b1;
    @(negedge clk); chk("t1_wb_handshake", wb_valid, 1);
    step(); wb_ready = 1'b0;
    set_bank(0, ALU_REM, 32'd9, 32'd5, 20, 21);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t1_wb_done", wb_valid, 0);
    chk("t1_grant_bank1", req_ready, 2'b10);
    step(); req_valid = 2'b01;
    @(negedge clk);
    chk("t1_b1_start", unit_start, 1);
    chk("t1_b1_op1", unit_op1, 100);
    step(); unit_done = 1'b1; unit_result = 32'd25;
    step(); unit_done = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("t1_b1_wb_bank", wb_bank, 1);
    chk("t1_b1_wb_data", wb_data, 25);
    chk("t1_b1_wb_rd", wb_rd, 11);
    step(); wb_ready = 1'b0;
    @(negedge clk); chk("t1_grant_bank0_again", req_ready, 2'b01);

    // Flush two cycles after accept, then a stray done while idle.
    set_bank(1, ALU_MULHU, 32'd3, 32'd5, 30, 31);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t2_start", unit_start, 1);
    chk("t2_no_kill", unit_kill, 0);
    step(); flush = 1'b1;
    @(negedge clk);
    chk("t2_kill", unit_kill, 1);
    chk("t2_flush_ready", req_ready, 2'b00);
    step(); flush = 1'b0; unit_done = 1'b1; unit_result = 32'hdead; req_valid = 2'b11;
    @(negedge clk);
    chk("t2_kill_once", unit_kill, 0);
    chk("t2_idle_rr_kept", req_ready, 2'b10);
    chk("t2_stray_no_wb", wb_valid, 0);

    // Done during the start cycle is ignored; only the later one writes back.
    step(); req_valid = 2'b00; unit_done = 1'b1; unit_result = 32'd111;
    @(negedge clk);
    chk("t3_start", unit_start, 1);
    chk("t3_no_wb", wb_valid, 0);
    step(); unit_done = 1'b0;
    @(negedge clk); chk("t3_start_done_ignored", wb_valid, 0);
    step(); unit_done = 1'b1; unit_result = 32'd222;
    step(); unit_done = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("t3_wb_valid", wb_valid, 1);
    chk("t3_wb_data", wb_data, 222);
    chk("t3_wb_bank", wb_bank, 1);

    // Reset in WB with rr_ptr at 1: wb_valid drops at once, bank0 first after.
    step(); wb_ready = 1'b0; req_valid = 2'b01;
    @(negedge clk); chk("t4_grant_bank0", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    step(); unit_done = 1'b1; unit_result = 32'd5;
    step(); unit_done = 1'b0;
    @(negedge clk); chk("t4_in_wb", wb_valid, 1);
    step(); rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    chk("t4_rst_wb_valid", wb_valid, 0);
    chk("t4_rst_ready", req_ready, 2'b00);
    step(); step(); rst_n = 1'b1;
    @(negedge clk); chk("t4_bank0_after_reset", req_ready, 2'b01);

    // Flush coinciding with a writeback handshake.
    step(); req_valid = 2'b00;
    step(); unit_done = 1'b1; unit_result = 32'd77;
    step(); unit_done = 1'b0; wb_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("t5_wb_valid", wb_valid, 1);
    chk("t5_wb_data", wb_data, 77);
    chk("t5_no_kill_in_wb", unit_kill, 0);
    step(); flush = 1'b0; wb_ready = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    chk("t5_wb_cleared", wb_valid, 0);
    chk("t5_idle_grant_bank1", req_ready, 2'b10);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int b = 0; b < N; b++) begin
        req_cmd[b] = alu_cmd_t'($urandom_range(0, 7));
        req_op1[b] = $urandom;
        req_op2[b] = $urandom;
        req_rd[b]  = PHYS_REGS_ADDR_WIDTH'($urandom);
        req_rob[b] = ROB_ADDR_WIDTH'($urandom);
      end
      req_valid   = N'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 19) == 0);
      unit_done   = ($urandom_range(0, 3) == 0);
      unit_result = $urandom;
      wb_ready    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
      end
    end

    step();
    clr();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_arbiter.md
MULDIV_ISSUE_ARBITER -- requirements
Module: muldiv_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default DISPATCH_WIDTH: number of issue banks sharing the mul/div unit.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  pipeline flush; abandons any in-flight operation.
REQ-005 req_valid  input  1 [0:NUM_REQ-1]  bank i holds a ready mul/div op.
REQ-006 req_ready  output  1 [0:NUM_REQ-1]  bank i's op accepted this cycle.
REQ-007 req_alu_cmd  input  common::alu_cmd_t [0:NUM_REQ-1]  operation.
REQ-008 req_op1, req_op2  input  32 [0:NUM_REQ-1]  operand values.
REQ-009 req_phys_rd  input  PHYS_REGS_ADDR_WIDTH [0:NUM_REQ-1]  destination physical register.
REQ-010 req_rob_addr  input  ROB_ADDR_WIDTH [0:NUM_REQ-1]  ROB entry.
REQ-011 unit_start  output  1  one-cycle start pulse to the mul/div unit.
REQ-012 unit_kill  output  1  one-cycle abort pulse to the unit.
REQ-013 unit_alu_cmd, unit_op1, unit_op2  output  alu_cmd_t/32/32  latched operation to the unit.
REQ-014 unit_done, unit_result  input  1/32  unit completion pulse and result.
REQ-015 wb_valid, wb_ready  output/input  1/1  writeback handshake.
REQ-016 wb_phys_rd, wb_rob_addr, wb_data, wb_bank  output  PHYS_REGS_ADDR_WIDTH/ROB_ADDR_WIDTH/32/DISPATCH_ADDR_WIDTH  writeback payload.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, WB.
REQ-018 In IDLE without flush, exactly one req_ready SHALL assert: first valid bank scanning from rr_ptr upward, mod NUM_REQ; none if no valid request.
REQ-019 On accept (req_valid&req_ready), payload and bank index SHALL latch, rr_ptr SHALL become (index+1) mod NUM_REQ, state -> BUSY.
REQ-020 unit_start SHALL pulse for exactly the first BUSY cycle; unit_* operands SHALL hold latched values throughout BUSY.
REQ-021 unit_done in BUSY, excluding the unit_start cycle, SHALL latch unit_result and move to WB; unit_done in any other state or cycle SHALL be ignored.
REQ-022 In WB, wb_valid SHALL be 1 with stable payload until wb_ready; on wb_valid&wb_ready state -> IDLE (next accept earliest next cycle).
REQ-023 req_ready SHALL be 0 in BUSY and WB.
REQ-024 flush SHALL force state -> IDLE next cycle from any state, force all req_ready to 0 that cycle, and pulse unit_kill that cycle if state is BUSY; rr_ptr unchanged.
REQ-025 flush with wb_valid&wb_ready same cycle: writeback counts as completed; flush still applies.
REQ-026 Combinational outputs SHALL have no combinational path from unit_done or unit_result.

Reset
REQ-027 While rst low: state=IDLE, rr_ptr=0, unit_start=0, unit_kill=0, wb_valid=0, all req_ready=0, latched payload and wb_data=0.
REQ-028 rst asserted mid-operation SHALL abandon it without unit_kill; the unit is reset by the same rst.

Configuration
REQ-029 Macro MULDIV_ARB_STATS_EN defined: 32-bit output counters stat_grants (accepts) and stat_busy_cycles (cycles not IDLE), wrapping at 2^32, reset to 0, not cleared by flush.
REQ-030 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-031 FSM state enum SHALL live in common; widths from parameters package (DISPATCH_WIDTH, PHYS_REGS_ADDR_WIDTH, ROB_ADDR_WIDTH, DISPATCH_ADDR_WIDTH).
REQ-032 The round-robin pick SHALL be a sub-module rr_picker (valid vector and pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-033 NUM_REQ=2, both valid from reset -> bank0 granted; after its writeback bank1 granted; then bank0.
REQ-034 Accept op1=6, op2=7, MUL; unit_done 3 cycles after unit_start with result 42 -> wb_valid with wb_data=42, correct phys_rd/rob_addr, held until wb_ready.
REQ-035 wb_ready held low 5 cycles -> wb_valid and payload stable 5 cycles; req_ready all 0 throughout.
REQ-036 flush 2 cycles after accept -> unit_kill single pulse, IDLE next cycle; a later stray unit_done produces no wb_valid.
REQ-037 unit_done in the unit_start cycle -> ignored; only the later done writes back.
REQ-038 rst low during WB -> wb_valid=0 immediately; after release bank0 granted first.
